mips_muldiv_seq: RTL

//  Multi-cycle sequencer for the HI/LO multiply/divide resource. Replaces the single-cycle HILO

---
 rtl/mips_pkg.sv | 33 +++
 rtl/mips_muldiv_seq_if.sv | 27 ++
 rtl/mips_muldiv_step.sv | 30 +++
 rtl/mips_muldiv_seq.sv | 131 +++++++++++++
 4 files changed

// File: rtl/mips_pkg.sv
// rtl/mips_pkg.sv - shared types and constants for the HI/LO multiply/divide sequencer
package mips_pkg;

   localparam int MULDIV_STEPS = 32;

   typedef enum logic [2:0] {
      OP_MULT  = 3'd0,
      OP_MULTU = 3'd1,
      OP_DIV   = 3'd2,
      OP_DIVU  = 3'd3,
      OP_MTHI  = 3'd4,
      OP_MTLO  = 3'd5
   } muldiv_op_t;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      ITER  = 2'd1,
      FIXUP = 2'd2
   } muldiv_state_t;

   function automatic logic is_arith(input muldiv_op_t op);
      return (op == OP_MULT) || (op == OP_MULTU) || (op == OP_DIV) || (op == OP_DIVU);
   endfunction

   function automatic logic is_signed_op(input muldiv_op_t op);
      return (op == OP_MULT) || (op == OP_DIV);
   endfunction

   function automatic logic is_div_op(input muldiv_op_t op);
      return (op == OP_DIV) || (op == OP_DIVU);
   endfunction

endpackage

// File: rtl/mips_muldiv_seq_if.sv
// rtl/mips_muldiv_seq_if.sv - request/stall/result bundle between execute stage and HI/LO unit
interface mips_muldiv_seq_if #(
   parameter int WIDTH = 32
) ();
   import mips_pkg::*;

   logic             op_valid;
   muldiv_op_t       op_code;
   logic [WIDTH-1:0] src_a;
   logic [WIDTH-1:0] src_b;
   logic             abort;
   logic             op_ready;
   logic             busy;
   logic [WIDTH-1:0] hi;
   logic [WIDTH-1:0] lo;

   modport master (
      output op_valid, op_code, src_a, src_b, abort,
      input  op_ready, busy, hi, lo
   );

   modport slave (
      input  op_valid, op_code, src_a, src_b, abort,
      output op_ready, busy, hi, lo
   );

endinterface

// File: rtl/mips_muldiv_step.sv
// rtl/mips_muldiv_step.sv - one combinational shift-add or restoring-divide iteration
// Divide mode leaves the new low bit zero; the caller inserts q_bit there.
module mips_muldiv_step #(
   parameter int WIDTH = 32
) (
   input  logic               div_mode,
   input  logic [2*WIDTH-1:0] acc,
   input  logic [WIDTH-1:0]   operand,
   output logic [2*WIDTH-1:0] acc_next,
   output logic               q_bit
);

   logic [WIDTH:0] sum;
   logic [WIDTH:0] rem_sh;
   logic [WIDTH:0] diff;

   always_comb begin
      sum    = {1'b0, acc[2*WIDTH-1:WIDTH]} + (acc[0] ? {1'b0, operand} : '0);
      // Remainder shifted left with the next dividend bit; WIDTH+1 bits keeps the carry.
      rem_sh = acc[2*WIDTH-1:WIDTH-1];
      diff   = rem_sh - {1'b0, operand};
      q_bit  = ~diff[WIDTH];
      if (div_mode) begin
         acc_next = {(q_bit ? diff[WIDTH-1:0] : rem_sh[WIDTH-1:0]), acc[WIDTH-2:0], 1'b0};
      end else begin
         acc_next = {sum, acc[WIDTH-1:1]};
      end
   end

endmodule

// File: rtl/mips_muldiv_seq.sv
// rtl/mips_muldiv_seq.sv - iterative MULT/DIV sequencer owning architectural HI/LO
module mips_muldiv_seq #(
   parameter int WIDTH = 32,
   parameter int STEPS = mips_pkg::MULDIV_STEPS
) (
   input logic                clk,
   input logic                rst_n,
   mips_muldiv_seq_if.slave   bus
);
   import mips_pkg::*;

   localparam int            CW   = $clog2(STEPS + 1);
   localparam logic [CW-1:0] LAST = CW'(STEPS - 1);

   muldiv_state_t      state_q, state_d;
   logic [CW-1:0]      cnt_q;
   logic [2*WIDTH-1:0] acc_q;
   logic [2*WIDTH-1:0] step_acc;
   logic               step_q;
   logic [WIDTH-1:0]   mag_a_q, mag_b_q;
   logic [WIDTH-1:0]   hi_q, lo_q;
   logic               div_q, res_neg_q, rem_neg_q, div_zero_q;

   logic               accept;
   logic               neg_a, neg_b;
   logic [WIDTH-1:0]   mag_a, mag_b;
   logic [2*WIDTH-1:0] prod_fix;
   logic [WIDTH-1:0]   fix_hi, fix_lo;

   assign bus.op_ready = (state_q == IDLE) && !bus.abort;
   assign bus.busy     = (state_q != IDLE);
   assign bus.hi       = hi_q;
   assign bus.lo       = lo_q;

   assign accept = bus.op_valid && bus.op_ready;
   assign neg_a  = is_signed_op(bus.op_code) && bus.src_a[WIDTH-1];
   assign neg_b  = is_signed_op(bus.op_code) && bus.src_b[WIDTH-1];
   assign mag_a  = neg_a ? -bus.src_a : bus.src_a;
   assign mag_b  = neg_b ? -bus.src_b : bus.src_b;

   mips_muldiv_step #(.WIDTH(WIDTH)) u_step (
      .div_mode (div_q),
      .acc      (acc_q),
      .operand  (div_q ? mag_b_q : mag_a_q),
      .acc_next (step_acc),
      .q_bit    (step_q)
   );

   always_comb begin
      state_d = state_q;
      case (state_q)
         IDLE:    if (accept && is_arith(bus.op_code)) state_d = ITER;
         ITER:    if (cnt_q == LAST) state_d = FIXUP;
         FIXUP:   state_d = IDLE;
         default: state_d = IDLE;
      endcase
      if (bus.abort) state_d = IDLE;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state_q <= IDLE;
      else        state_q <= state_d;
   end

   // Sign correction: product negated as a 2*WIDTH quantity; quotient and remainder separately.
   always_comb begin
      prod_fix = res_neg_q ? -acc_q : acc_q;
      fix_hi   = prod_fix[2*WIDTH-1:WIDTH];
      fix_lo   = prod_fix[WIDTH-1:0];
      if (div_q) begin
         if (div_zero_q) begin
            fix_hi = rem_neg_q ? -mag_a_q : mag_a_q;
            fix_lo = '1;
         end else begin
            fix_hi = rem_neg_q ? -acc_q[2*WIDTH-1:WIDTH] : acc_q[2*WIDTH-1:WIDTH];
            fix_lo = res_neg_q ? -acc_q[WIDTH-1:0] : acc_q[WIDTH-1:0];
         end
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cnt_q      <= '0;
         acc_q      <= '0;
         mag_a_q    <= '0;
         mag_b_q    <= '0;
         hi_q       <= '0;
         lo_q       <= '0;
         div_q      <= 1'b0;
         res_neg_q  <= 1'b0;
         rem_neg_q  <= 1'b0;
         div_zero_q <= 1'b0;
      end else begin
         case (state_q)
            IDLE: begin
               if (accept) begin
                  if (bus.op_code == OP_MTHI) begin
                     hi_q <= bus.src_a;
                  end else if (bus.op_code == OP_MTLO) begin
                     lo_q <= bus.src_a;
                  end else if (is_arith(bus.op_code)) begin
                     mag_a_q    <= mag_a;
                     mag_b_q    <= mag_b;
                     res_neg_q  <= neg_a ^ neg_b;
                     rem_neg_q  <= neg_a;
                     div_q      <= is_div_op(bus.op_code);
                     div_zero_q <= (bus.src_b == '0);
                     cnt_q      <= '0;
                     acc_q      <= is_div_op(bus.op_code) ? {{WIDTH{1'b0}}, mag_a}
                                                          : {{WIDTH{1'b0}}, mag_b};
                  end
               end
            end
            ITER: begin
               if (!bus.abort) begin
                  acc_q <= div_q ? {step_acc[2*WIDTH-1:1], step_q} : step_acc;
                  cnt_q <= cnt_q + CW'(1);
               end
            end
            FIXUP: begin
               if (!bus.abort) begin
                  hi_q <= fix_hi;
                  lo_q <= fix_lo;
               end
            end
            default: ;
         endcase
      end
   end

endmodule
